// File: rtl/writeback_ctrl_if.sv
// Handshake, job-control and dual BRAM write bus between the layer FSM and
// the writeback sequencer.
interface writeback_ctrl_if;
  logic        start;
  logic [11:0] base_addr;
  logic [15:0] byte_total;
  logic        dst_sel;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  sum1;
  logic [7:0]  sum2;
  logic [7:0]  sum3;
  logic [7:0]  sum4;
  logic [7:0]  sum5;
  logic        we_BRAM32k_1;
  logic        we_BRAM32k_2;
  logic [11:0] addr_BRAM32k_1;
  logic [11:0] addr_BRAM32k_2;
  logic [63:0] din_BRAM32k_1;
  logic [63:0] din_BRAM32k_2;
  logic        busy;
  logic        done;

  modport master (
    output start, base_addr, byte_total, dst_sel, in_valid,
    output sum1, sum2, sum3, sum4, sum5,
    input  in_ready, busy, done,
    input  we_BRAM32k_1, we_BRAM32k_2, addr_BRAM32k_1, addr_BRAM32k_2,
    input  din_BRAM32k_1, din_BRAM32k_2
  );

  modport slave (
    input  start, base_addr, byte_total, dst_sel, in_valid,
    input  sum1, sum2, sum3, sum4, sum5,
    output in_ready, busy, done,
    output we_BRAM32k_1, we_BRAM32k_2, addr_BRAM32k_1, addr_BRAM32k_2,
    output din_BRAM32k_1, din_BRAM32k_2
  );
endinterface

// File: rtl/writeback_ctrl.sv
// PE-group writeback sequencer: adds five signed partial sums per transfer,
// saturates to a byte, packs eight bytes per word and writes them to a BRAM port.
module writeback_ctrl (
  input  logic            clk,
  input  logic            rst,
  writeback_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FLUSH, DONE} state_e;

  state_e              state_q;
  logic                in_ready_q;
  logic                busy_q;
  logic                done_q;
  logic                we1_q;
  logic                we2_q;
  logic [11:0]         addr1_q;
  logic [11:0]         addr2_q;
  logic [63:0]         din1_q;
  logic [63:0]         din2_q;
  logic [15:0]         total_q;
  logic [15:0]         cnt_q;
  logic [11:0]         cur_addr_q;
  logic                sel_q;
  logic                s1_valid_q;
  logic signed [10:0]  p1_q;
  logic signed [10:0]  p2_q;
  logic                s2_valid_q;
  logic                full_q;
  logic [2:0]          lane_q;
  logic [63:0]         pack_q;

  logic                xfer;
  logic signed [10:0]  p1_d;
  logic signed [10:0]  p2_d;
  logic signed [10:0]  r_sum;
  logic [7:0]          sat_byte;
  logic [63:0]         pack_base;
  logic [63:0]         pack_d;
  logic [15:0]         cnt_d;
  logic                pipe_empty;
  logic                flush_now;
  logic                emit_now;

  function automatic logic signed [10:0] sext(input logic [7:0] v);
    return {{3{v[7]}}, v};
  endfunction

  assign xfer = bus.in_valid & in_ready_q;

  always_comb begin
    p1_d  = sext(bus.sum1) + sext(bus.sum2) + sext(bus.sum3);
    p2_d  = sext(bus.sum4) + sext(bus.sum5);
    r_sum = p1_q + p2_q;
    if (r_sum > 11'sd127) begin
      sat_byte = 8'h7F;
    end else if (r_sum < -11'sd128) begin
      sat_byte = 8'h80;
    end else begin
      sat_byte = r_sum[7:0];
    end
  end

  // A full word is emitted in the same cycle that lane 0 of the next word may land.
  assign pack_base = full_q ? 64'd0 : pack_q;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign pack_d[8*gi +: 8] = (s1_valid_q && lane_q == 3'(gi)) ? sat_byte
                                                                    : pack_base[8*gi +: 8];
    end
  endgenerate

  assign cnt_d      = cnt_q + 16'd1;
  assign pipe_empty = !s1_valid_q && !s2_valid_q;
  assign flush_now  = (state_q == DRAIN) && pipe_empty && (lane_q != 3'd0);
  assign emit_now   = full_q || flush_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we1_q      <= 1'b0;
      we2_q      <= 1'b0;
      addr1_q    <= 12'd0;
      addr2_q    <= 12'd0;
      din1_q     <= 64'd0;
      din2_q     <= 64'd0;
      total_q    <= 16'd0;
      cnt_q      <= 16'd0;
      cur_addr_q <= 12'd0;
      sel_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      p1_q       <= 11'sd0;
      p2_q       <= 11'sd0;
      s2_valid_q <= 1'b0;
      full_q     <= 1'b0;
      lane_q     <= 3'd0;
      pack_q     <= 64'd0;
    end else begin
      we1_q      <= 1'b0;
      we2_q      <= 1'b0;
      s1_valid_q <= xfer;
      if (xfer) begin
        p1_q <= p1_d;
        p2_q <= p2_d;
      end
      s2_valid_q <= s1_valid_q;
      full_q     <= s1_valid_q && (lane_q == 3'd7);
      pack_q     <= pack_d;
      if (s1_valid_q) begin
        lane_q <= lane_q + 3'd1;
      end

      if (emit_now) begin
        if (sel_q) begin
          we2_q   <= 1'b1;
          addr2_q <= cur_addr_q;
          din2_q  <= pack_q;
        end else begin
          we1_q   <= 1'b1;
          addr1_q <= cur_addr_q;
          din1_q  <= pack_q;
        end
        cur_addr_q <= cur_addr_q + 12'd1;
      end

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q     <= 1'b1;
            total_q    <= bus.byte_total;
            cur_addr_q <= bus.base_addr;
            sel_q      <= bus.dst_sel;
            cnt_q      <= 16'd0;
            if (bus.byte_total == 16'd0) begin
              state_q <= DONE;
            end else begin
              state_q    <= RUN;
              in_ready_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            cnt_q <= cnt_d;
            if (cnt_d == total_q) begin
              in_ready_q <= 1'b0;
              state_q    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            if (lane_q != 3'd0) begin
              state_q <= FLUSH;
              pack_q  <= 64'd0;
              lane_q  <= 3'd0;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        FLUSH: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          // A zero-length job enters with done low, so its pulse lands one cycle later.
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.we_BRAM32k_1   = we1_q;
  assign bus.we_BRAM32k_2   = we2_q;
  assign bus.addr_BRAM32k_1 = addr1_q;
  assign bus.addr_BRAM32k_2 = addr2_q;
  assign bus.din_BRAM32k_1  = din1_q;
  assign bus.din_BRAM32k_2  = din2_q;

endmodule

// File: doc/writeback_ctrl.md
# writeback_ctrl

Sequencer for the PE-group writeback path. It accepts one set of five 8-bit PE-group partial sums per cycle and adds them in a two-stage pipeline. It packs eight results into a 64-bit word and issues single-cycle writes into one of the two 32 KB BRAM ports. Address generation, byte-lane ordering, job length, tail padding and completion signalling all live here, so the layer FSM only issues a start pulse and streams sums.

## Interface
- No parameters; all widths fixed.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job start; sampled only in IDLE.
- base_addr  in  12  first BRAM word address of the job; latched on accepted start.
- byte_total  in  16  number of result bytes in the job (0..65535); latched on accepted start.
- dst_sel  in  1  0 selects port 1, 1 selects port 2; latched on accepted start.
- in_valid  in  1  sum1..sum5 valid this cycle.
- in_ready  out  1  block accepts sums this cycle; a transfer occurs when in_valid and in_ready are both 1.
- sum1..sum5  in  8 each  signed two's-complement partial sums.
- we_BRAM32k_1 / we_BRAM32k_2  out  1 each  write enable for the selected port; one-cycle pulse per word.
- addr_BRAM32k_1 / addr_BRAM32k_2  out  12 each  word address for each port.
- din_BRAM32k_1 / din_BRAM32k_2  out  64 each  write data for each port.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job completion.

## Operation
- FSM states: IDLE, RUN, DRAIN, FLUSH, DONE.
- IDLE → RUN on start when byte_total ≠ 0.
- IDLE → DONE on start when byte_total = 0. No writes are issued.
- RUN: in_ready = 1. An accepted-byte counter increments on each transfer.
  - When the counter reaches byte_total, in_ready drops the next cycle.
  - The FSM then moves to DRAIN.
- DRAIN: waits for the pipeline to hold no valid data.
  - If the lane counter is nonzero, DRAIN → FLUSH.
  - Otherwise DRAIN → DONE.
- FLUSH: writes the partial word. Unfilled lanes are 0. The FSM then moves to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- start outside IDLE is ignored.
- Stage 1 registers two partial sums, each sign-extended to 11 bits:
  - p1 = sum1 + sum2 + sum3
  - p2 = sum4 + sum5
- Stage 2 computes r = p1 + p2 and saturates it to signed 8 bits, range −128..127.
  - The saturated byte is written into pack-register lane k, bits [8k+7:8k].
  - k is the 3-bit lane counter; it starts at 0 and wraps 7 → 0.
- When lane 7 is written, the full word is emitted next cycle:
  - din = packed word, addr = current address, we = 1 on the dst_sel port only.
- The current address starts at base_addr and increments after every emitted word, including FLUSH.
  - It wraps from 4095 to 0.
- Unselected-port outputs hold their values, with we = 0.
- The pack register clears to 0 after each emission.

## Timing
- Reset values:
  - in_ready, busy, done, both we = 0.
  - Both addr = 0, both din = 0.
  - FSM = IDLE; all counters and the pack register = 0.
- Start accepted at cycle s → busy = 1 and in_ready = 1 from cycle s+1.
- Transfer at cycle t → stage-1 register valid at t+1, lane written at t+2.
  - If that lane is 7, we pulses during t+3.
  - Write latency is 3 cycles from the transfer of a word's last byte.
- Full-rate streaming is sustained: one write every 8 cycles with no bubbles. in_valid gaps simply delay the pipeline.
- Last transfer at cycle L:
  - in_ready = 0 from L+1.
  - If no FLUSH is needed, done pulses at L+4.
  - With a FLUSH, the FLUSH write occurs at L+4 and done pulses at L+5.
- Reset asserted mid-job: on the next edge all state returns to reset values, no write is issued, and done is not pulsed.
- BRAM never back-pressures; a write is always taken in its cycle.

## Test plan
- Saturation:
  - All sums = 0x7F → result 0x7F (raw 635).
  - All sums = 0x80 → 0x80.
  - Sums 10, 20, −5, 3, 1 → 0x1D.
- Full word: base_addr = 0x010, byte_total = 8, dst_sel = 0, lane i result = i+1 → one write.
  - we_BRAM32k_1 pulse, addr 0x010, din = 0x0807060504030201.
  - Port 2 we stays 0; done pulses 4 cycles after the last transfer.
- Tail flush: byte_total = 11, dst_sel = 1, all results 0xAA → two writes on port 2.
  - addr base gets 0xAAAAAAAAAAAAAAAA.
  - addr base+1 gets 0x0000000000AAAAAA.
- Address wrap: base_addr = 0xFFF, byte_total = 16 → writes at 0xFFF then 0x000.
- in_valid toggling every other cycle over 8 bytes → the same single word as streaming, written 3 cycles after the 8th transfer.
- Zero-length job: byte_total = 0 → done two cycles after start with no we.
- Reset during a job: reset after 5 transfers → no write, no done, all outputs at reset values.
